// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back / write-allocate data cache with hit/miss statistics.
// Replacement policy: true LRU when CACHE_LRU_EN is defined, per-set round-robin otherwise.
module set_assoc_cache #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [ADDR_WIDTH-1:0]                cpu_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_wdata,
    output logic [DATA_WIDTH-1:0]                cpu_rdata,
    output logic                                 cpu_ready,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                                 mem_ready,
    output logic [31:0]                          hit_count,
    output logic [31:0]                          miss_count
);
    localparam int BYTE_OFF  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS  = BYTE_OFF + WORD_BITS;
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int LINE_W    = DATA_WIDTH * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t              state_q, state_d;
    logic [WAY_BITS-1:0] victim_q, victim_d;
    logic                miss_q, miss_d;
    logic [TAG_BITS-1:0] req_tag_q, req_tag_d;
    logic [IDX_BITS-1:0] req_idx_q, req_idx_d;
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    logic                valid_q [SETS][WAYS];
    logic                valid_d [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic                dirty_d [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_d   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];
    logic [LINE_W-1:0]   data_d  [SETS][WAYS];

`ifdef CACHE_LRU_EN
    localparam logic [WAY_BITS-1:0] AGE_MAX = WAY_BITS'(WAYS - 1);
    logic [WAY_BITS-1:0] age_q [SETS][WAYS];
    logic [WAY_BITS-1:0] age_d [SETS][WAYS];
    logic                touch_en;
    logic [IDX_BITS-1:0] touch_idx;
    logic [WAY_BITS-1:0] touch_way;
`else
    logic [WAY_BITS-1:0] rr_q [SETS];
    logic [WAY_BITS-1:0] rr_d [SETS];
`endif

    logic [IDX_BITS-1:0]  cpu_idx;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic [WORD_BITS-1:0] cpu_word;
    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [WAY_BITS-1:0]  victim;
    logic [LINE_W-1:0]    hit_line;
    logic                 unused_addr_bits;

    assign cpu_idx          = cpu_addr[OFF_BITS +: IDX_BITS];
    assign cpu_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign cpu_word         = cpu_addr[BYTE_OFF +: WORD_BITS];
    assign unused_addr_bits = ^cpu_addr[BYTE_OFF-1:0];
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[cpu_idx][w] && tag_q[cpu_idx][w] == cpu_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        hit_line = data_q[cpu_idx][hit_way];
    end

    always_comb begin
        logic found;
`ifdef CACHE_LRU_EN
        victim = '0;
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[cpu_idx][w] > age_q[cpu_idx][victim]) victim = WAY_BITS'(w);
        end
`else
        victim = rr_q[cpu_idx];
`endif
        found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[cpu_idx][w]) begin
                found  = 1'b1;
                victim = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        miss_d       = miss_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
`ifdef CACHE_LRU_EN
        age_d        = age_q;
        touch_en     = 1'b0;
        touch_idx    = '0;
        touch_way    = '0;
`else
        rr_d         = rr_q;
`endif
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (!cpu_req) begin
                    miss_d = 1'b0;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = hit_line[cpu_word*DATA_WIDTH +: DATA_WIDTH];
                    if (cpu_we) begin
                        data_d[cpu_idx][hit_way][cpu_word*DATA_WIDTH +: DATA_WIDTH] = cpu_wdata;
                        dirty_d[cpu_idx][hit_way] = 1'b1;
                    end
                    if (miss_q) miss_count_d = miss_count_q + 32'd1;
                    else        hit_count_d  = hit_count_q + 32'd1;
                    miss_d = 1'b0;
`ifdef CACHE_LRU_EN
                    touch_en  = 1'b1;
                    touch_idx = cpu_idx;
                    touch_way = hit_way;
`endif
                end else begin
                    victim_d  = victim;
                    req_tag_d = cpu_tag;
                    req_idx_d = cpu_idx;
                    miss_d    = 1'b1;
                    state_d   = (valid_q[cpu_idx][victim] && dirty_q[cpu_idx][victim])
                              ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[req_idx_q][victim_q], req_idx_q, {OFF_BITS{1'b0}}};
                mem_wdata = data_q[req_idx_q][victim_q];
                if (mem_ready) state_d = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag_q, req_idx_q, {OFF_BITS{1'b0}}};
                if (mem_ready) begin
                    data_d[req_idx_q][victim_q]  = mem_rdata;
                    valid_d[req_idx_q][victim_q] = 1'b1;
                    dirty_d[req_idx_q][victim_q] = 1'b0;
                    tag_d[req_idx_q][victim_q]   = req_tag_q;
                    state_d                      = IDLE;
`ifdef CACHE_LRU_EN
                    touch_en  = 1'b1;
                    touch_idx = req_idx_q;
                    touch_way = victim_q;
`else
                    rr_d[req_idx_q] = rr_q[req_idx_q] + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CACHE_LRU_EN
        // Ties are aged too (<=), so ways all at age 0 after reset still get ordered.
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) != touch_way
                    && age_q[touch_idx][w] <= age_q[touch_idx][touch_way]
                    && age_q[touch_idx][w] != AGE_MAX)
                    age_d[touch_idx][w] = age_q[touch_idx][w] + 1'b1;
            end
            age_d[touch_idx][touch_way] = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            miss_q       <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
`ifdef CACHE_LRU_EN
                    age_q[s][w]   <= '0;
`endif
                end
`ifndef CACHE_LRU_EN
                rr_q[s] <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_q       <= miss_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
`ifdef CACHE_LRU_EN
            age_q        <= age_d;
`else
            rr_q         <= rr_d;
`endif
        end
    end

    // Tags and line data are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios plus random traffic
// checked against a line/word-level cache model and a flat main-memory model.
module tb_set_assoc_cache;
    localparam int AW = 32, DW = 32, NW = 2, NS = 16, WPL = 4, LW = DW * WPL;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;
    logic [31:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAYS(NW), .SETS(NS), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] phys_mem [int unsigned];
    logic [LW-1:0] ref_mem  [int unsigned];
    int            mem_delay = 0;
    bit            stab_bad  = 0;
    bit            log_we    [$];
    logic [31:0]   log_addr  [$];
    logic [LW-1:0] log_wdata [$];

    bit            resp_busy = 0;
    int            resp_cnt  = 0;
    bit            resp_we;
    logic [31:0]   resp_addr;
    logic [LW-1:0] resp_wd;

    function automatic logic [LW-1:0] init_line(input logic [31:0] la);
        logic [LW-1:0] l;
        for (int i = 0; i < WPL; i++) l[i*DW +: DW] = la ^ 32'h5A00_0000 ^ (32'(i) << 16);
        return l;
    endfunction

    // Memory responder: acts 1 time unit after each rising edge.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                resp_busy = 1'b0;
            end
            if (resp_busy && !mem_req) resp_busy = 1'b0;
            if (resp_busy) begin
                if (mem_addr !== resp_addr || mem_we !== resp_we || (resp_we && mem_wdata !== resp_wd))
                    stab_bad = 1'b1;
                if (resp_cnt == 0) begin
                    if (resp_we) phys_mem[resp_addr] = resp_wd;
                    else mem_rdata = phys_mem.exists(resp_addr) ? phys_mem[resp_addr] : init_line(resp_addr);
                    mem_ready = 1'b1;
                end else begin
                    resp_cnt--;
                end
            end else if (mem_req) begin
                resp_busy = 1'b1;
                resp_cnt  = mem_delay;
                resp_we   = mem_we;
                resp_addr = mem_addr;
                resp_wd   = mem_wdata;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
            end
        end
    end

    // Reference model: what a 2-way write-back cache must hold, in line/word terms.
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    logic [31:0]   m_tag   [NS][NW];
    logic [LW-1:0] m_line  [NS][NW];
    int            m_stamp [NS][NW];
    int            m_rr    [NS];
    int            m_time, m_hits, m_misses;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_stamp[s][w] = 0;
            end
            m_rr[s] = 0;
        end
        m_time = 0; m_hits = 0; m_misses = 0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output bit hit);
        int unsigned idx  = (addr / 16) % NS;
        logic [31:0] tag  = addr / (16 * NS);
        int          word = (addr / 4) % WPL;
        int          way  = -1;
        logic [31:0] la;
        for (int w = 0; w < NW; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = NW - 1; w >= 0; w--) if (!m_valid[idx][w]) way = w;
            if (way < 0) begin
`ifdef CACHE_LRU_EN
                way = 0;
                for (int w = 1; w < NW; w++) if (m_stamp[idx][w] < m_stamp[idx][way]) way = w;
`else
                way = m_rr[idx];
`endif
            end
            if (m_valid[idx][way] && m_dirty[idx][way])
                ref_mem[(m_tag[idx][way] * NS + idx) * 16] = m_line[idx][way];
            la = (tag * NS + idx) * 16;
            m_line[idx][way]  = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
            m_valid[idx][way] = 1;
            m_dirty[idx][way] = 0;
            m_tag[idx][way]   = tag;
            m_rr[idx]         = (m_rr[idx] + 1) % NW;
            m_misses++;
        end else begin
            m_hits++;
        end
        m_time++;
        m_stamp[idx][way] = m_time;
        if (we) begin
            m_line[idx][way][word*DW +: DW] = wd;
            m_dirty[idx][way] = 1;
        end
        rd = m_line[idx][way][word*DW +: DW];
    endtask

    task automatic preload(input logic [31:0] la, input logic [LW-1:0] line);
        phys_mem[la] = line;
        ref_mem[la]  = line;
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
    endtask

    // Called and returns 1 unit after a rising edge; cyc = cycles before cpu_ready.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output int cyc);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        cyc = 0;
        rd  = '0;
        while (1) begin
            @(negedge clk);
            if (cpu_ready) begin
                rd = cpu_rdata;
                break;
            end
            cyc++;
            if (cyc > 100) begin
                checks++; errors++;
                $display("FAIL access_timeout: addr %h no cpu_ready within 100 cycles", addr);
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (cpu_rdata !== '0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [LW-1:0] line;
        logic [31:0]   rd, mrd;
        int            cyc;
        bit            mhit;
        line = init_line(32'h40);
        line[31:0] = 32'h1111_1111;
        preload(32'h40, line);
        clear_log();
        do_access(0, 32'h40, 0, rd, cyc);
        model_access(0, 32'h40, 0, mrd, mhit);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL basic_rdata: got %h want 11111111", rd); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL basic_miss_latency: got %0d want 3", cyc); end
        checks++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h40) begin
            errors++; $display("FAIL basic_refill_txn: count %0d (want 1 refill at 00000040)", log_addr.size());
        end
        do_access(0, 32'h44, 0, rd, cyc);
        model_access(0, 32'h44, 0, mrd, mhit);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL basic_hit_latency: got %0d want 0", cyc); end
        checks++; if (rd !== mrd) begin errors++; $display("FAIL basic_hit_rdata: got %h want %h", rd, mrd); end
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++; $display("FAIL basic_counters: got hit=%0d miss=%0d want 1/1", hit_count, miss_count);
        end
    endtask

    task automatic test_replacement();
        logic [31:0] rd, mrd;
        int          cyc;
        bit          mhit;
        do_access(0, 32'h40, 0, rd, cyc);  model_access(0, 32'h40, 0, mrd, mhit);
        do_access(0, 32'h140, 0, rd, cyc); model_access(0, 32'h140, 0, mrd, mhit);
        checks++; if (rd !== mrd) begin errors++; $display("FAIL repl_rdata_140: got %h want %h", rd, mrd); end
        do_access(1, 32'h40, 32'hDEAD_BEEF, rd, cyc); model_access(1, 32'h40, 32'hDEAD_BEEF, mrd, mhit);
        clear_log();
        do_access(0, 32'h240, 0, rd, cyc); model_access(0, 32'h240, 0, mrd, mhit);
        checks++; if (rd !== mrd) begin errors++; $display("FAIL repl_rdata_240: got %h want %h", rd, mrd); end
`ifdef CACHE_LRU_EN
        checks++; if (cyc !== 3) begin errors++; $display("FAIL repl_latency: got %0d want 3", cyc); end
        checks++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h240) begin
            errors++; $display("FAIL repl_txns: count %0d (want only refill of 00000240)", log_addr.size());
        end
`else
        checks++; if (cyc !== 5) begin errors++; $display("FAIL repl_latency: got %0d want 5", cyc); end
        checks++; if (log_addr.size() !== 2 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h40
                      || log_wdata[0][31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL repl_writeback: count %0d (want writeback of 00000040 word0 deadbeef)", log_addr.size());
        end
        checks++; if (log_addr.size() < 2 || log_we[1] !== 1'b0 || log_addr[1] !== 32'h240) begin
            errors++; $display("FAIL repl_refill: count %0d (want refill of 00000240 second)", log_addr.size());
        end
`endif
    endtask

    task automatic test_delay();
        logic [31:0] rd, mrd;
        int          cyc;
        bit          mhit;
        mem_delay = 5;
        stab_bad  = 0;
        clear_log();
        do_access(0, 32'h300, 0, rd, cyc);
        model_access(0, 32'h300, 0, mrd, mhit);
        mem_delay = 0;
        checks++; if (cyc !== 8) begin errors++; $display("FAIL delay_latency: got %0d want 8", cyc); end
        checks++; if (stab_bad !== 1'b0) begin errors++; $display("FAIL delay_stable: mem_req/addr changed while waiting"); end
        checks++; if (rd !== mrd) begin errors++; $display("FAIL delay_rdata: got %h want %h", rd, mrd); end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL delay_txn_count: got %0d want 1", log_addr.size()); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd, mrd;
        int          cyc;
        bit          mhit;
        do_access(1, 32'h80, 32'hCAFE_F00D, rd, cyc);
        model_access(1, 32'h80, 32'hCAFE_F00D, mrd, mhit);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL wmiss_latency: got %0d want 3", cyc); end
        do_access(0, 32'h180, 0, rd, cyc); model_access(0, 32'h180, 0, mrd, mhit);
        clear_log();
        do_access(0, 32'h280, 0, rd, cyc); model_access(0, 32'h280, 0, mrd, mhit);
        checks++; if (log_addr.size() !== 2 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h80
                      || log_wdata[0][31:0] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wmiss_writeback: count %0d (want writeback of 00000080 word0 cafef00d)", log_addr.size());
        end
        do_access(0, 32'h80, 0, rd, cyc); model_access(0, 32'h80, 0, mrd, mhit);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL wmiss_readback: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd, mrd;
        int          cyc;
        bit          mhit;
        mem_delay = 5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3C0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
        @(posedge clk);
        #1;
        model_reset();
        mem_delay = 0;
        clear_log();
        do_access(0, 32'h3C0, 0, rd, cyc);
        model_access(0, 32'h3C0, 0, mrd, mhit);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL rstmid_remiss: latency got %0d want 3", cyc); end
        checks++; if (rd !== mrd) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", rd, mrd); end
        checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_counts: got hit=%0d miss=%0d want 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, mrd, a;
        int          cyc, base;
        bit          mhit, bad;
        do_access(0, 32'h40, 0, rd, cyc);
        model_access(0, 32'h40, 0, mrd, mhit);
        base = m_hits;
        bad  = 0;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 1) ? 32'h44 : 32'h40;
            cpu_addr = a;
            model_access(0, a, 0, mrd, mhit);
            @(negedge clk);
            checks++;
            if (cpu_ready !== 1'b1 || cpu_rdata !== mrd || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ready=%b rdata=%h mem_req=%b want 1/%h/0", i, cpu_ready, cpu_rdata, mem_req, mrd);
            end
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        checks++; if (hit_count !== 32'(base + 8)) begin
            errors++; $display("FAIL b2b_hit_count: got %0d want %0d", hit_count, base + 8);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd;
        int          cyc;
        bit          we, mhit;
        for (int n = 0; n < 300; n++) begin
            we        = 1'($urandom % 2);
            a         = 32'($urandom_range(0, 255)) * 4;
            wd        = $urandom;
            mem_delay = $urandom_range(0, 2);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            do_access(we, a, wd, rd, cyc);
            model_access(we, a, wd, mrd, mhit);
            checks++;
            if ((cyc == 0) !== mhit) begin
                errors++; $display("FAIL rand_hitmiss: addr %h latency %0d model_hit %0d", a, cyc, mhit);
            end
            if (!we) begin
                checks++;
                if (rd !== mrd) begin errors++; $display("FAIL rand_rdata: addr %h got %h want %h", a, rd, mrd); end
            end
        end
        mem_delay = 0;
        checks++; if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
            errors++; $display("FAIL rand_counters: got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, m_hits, m_misses);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_replacement();
        test_delay();
        test_write_miss();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
